// File: rtl/uart_tx_arbiter_if.sv
// Request and transmitter-side bundle between N_REQ byte producers, the
// round-robin arbiter and the shared UART transmitter.
interface uart_tx_arbiter_if #(
  parameter int unsigned N_REQ = 4
);
  logic [N_REQ-1:0]   req_valid;
  logic [8*N_REQ-1:0] req_data;
  logic [N_REQ-1:0]   req_ready;
  logic [2:0]         cfg_baud;
  logic               cfg_parity;
  logic [7:0]         tx_data_in;
  logic               tx_data_in_ready;
  logic [2:0]         tx_baud;
  logic               tx_parity;
  logic               busy;
  logic [2:0]         grant_id;

  modport master (
    output req_valid, req_data, cfg_baud, cfg_parity,
    input  req_ready, tx_data_in, tx_data_in_ready, tx_baud, tx_parity, busy, grant_id
  );

  modport slave (
    input  req_valid, req_data, cfg_baud, cfg_parity,
    output req_ready, tx_data_in, tx_data_in_ready, tx_baud, tx_parity, busy, grant_id
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one UART transmitter among N_REQ byte producers;
// frame length is timed locally since the transmitter gives no busy feedback.
//
// state  | meaning
// S_IDLE | no frame in flight; pick a winner from pending requests
// S_LOAD | second cycle of the data_in_ready strobe
// S_WAIT | frame plus guard bits running; down-counter to terminal zero
module uart_tx_arbiter #(
  parameter int unsigned FCLK       = 500_000_000,
  parameter int unsigned N_REQ      = 4,
  parameter int unsigned GUARD_BITS = 1
) (
  input logic              clk,
  input logic              rst,
  uart_tx_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  function automatic logic [31:0] f_bit_cycles(input logic [2:0] baud);
    logic [31:0] bc;
    case (baud)
      3'd0:    bc = 32'(FCLK / 1200);
      3'd1:    bc = 32'(FCLK / 2400);
      3'd2:    bc = 32'(FCLK / 4800);
      3'd3:    bc = 32'(FCLK / 9600);
      3'd4:    bc = 32'(FCLK / 57600);
      3'd5:    bc = 32'(FCLK / 115200);
      3'd6:    bc = 32'(FCLK / 230400);
      default: bc = 32'(FCLK / 460800);
    endcase
    return bc;
  endfunction

  state_t             r_state, w_state_nxt;
  logic [2:0]         r_ptr, w_ptr_nxt;
  logic [31:0]        r_count, w_count_nxt;
  logic [N_REQ-1:0]   r_req_ready, w_req_ready_nxt;
  logic [7:0]         r_tx_data, w_tx_data_nxt;
  logic               r_tx_dir, w_tx_dir_nxt;
  logic [2:0]         r_tx_baud, w_tx_baud_nxt;
  logic               r_tx_par, w_tx_par_nxt;
  logic               r_busy, w_busy_nxt;
  logic [2:0]         r_grant_id, w_grant_id_nxt;

  logic               w_any;
  logic               w_hit_hi, w_hit_lo;
  logic [2:0]         w_win_hi, w_win_lo, w_winner;
  logic [N_REQ-1:0]   w_onehot;
  logic [7:0]         w_byte;
  logic [31:0]        w_frame_cycles;

  // Winner is the lowest pending index at or above ptr, else the lowest below it.
  always_comb begin
    w_hit_hi = 1'b0;
    w_hit_lo = 1'b0;
    w_win_hi = 3'd0;
    w_win_lo = 3'd0;
    for (int i = int'(N_REQ) - 1; i >= 0; i--) begin
      if (bus.req_valid[i]) begin
        if (i >= int'(r_ptr)) begin
          w_hit_hi = 1'b1;
          w_win_hi = 3'(i);
        end else begin
          w_hit_lo = 1'b1;
          w_win_lo = 3'(i);
        end
      end
    end
    w_any    = w_hit_hi | w_hit_lo;
    w_winner = w_hit_hi ? w_win_hi : w_win_lo;
  end

  always_comb begin
    w_onehot = '0;
    w_byte   = 8'd0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      if (w_winner == 3'(i)) begin
        w_onehot[i] = 1'b1;
        w_byte      = bus.req_data[8*i +: 8];
      end
    end
  end

  assign w_frame_cycles = f_bit_cycles(bus.cfg_baud) *
                          (32'd10 + {31'd0, bus.cfg_parity} + 32'(GUARD_BITS));

  always_comb begin
    w_state_nxt     = r_state;
    w_ptr_nxt       = r_ptr;
    w_count_nxt     = r_count;
    w_req_ready_nxt = '0;
    w_tx_data_nxt   = r_tx_data;
    w_tx_dir_nxt    = 1'b0;
    w_tx_baud_nxt   = r_tx_baud;
    w_tx_par_nxt    = r_tx_par;
    w_busy_nxt      = r_busy;
    w_grant_id_nxt  = r_grant_id;
    unique case (r_state)
      S_IDLE: begin
        if (w_any) begin
          w_state_nxt     = S_LOAD;
          w_req_ready_nxt = w_onehot;
          w_tx_data_nxt   = w_byte;
          w_tx_dir_nxt    = 1'b1;
          w_tx_baud_nxt   = bus.cfg_baud;
          w_tx_par_nxt    = bus.cfg_parity;
          w_busy_nxt      = 1'b1;
          w_grant_id_nxt  = w_winner;
          w_count_nxt     = w_frame_cycles - 32'd1;
          w_ptr_nxt       = (w_winner == 3'(N_REQ - 1)) ? 3'd0 : w_winner + 3'd1;
        end
      end
      S_LOAD: begin
        w_state_nxt  = S_WAIT;
        w_tx_dir_nxt = 1'b1;
        w_count_nxt  = r_count - 32'd1;
      end
      S_WAIT: begin
        if (r_count == 32'd0) begin
          w_state_nxt = S_IDLE;
          w_busy_nxt  = 1'b0;
        end else begin
          w_count_nxt = r_count - 32'd1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_ptr       <= 3'd0;
      r_count     <= 32'd0;
      r_req_ready <= '0;
      r_tx_data   <= 8'd0;
      r_tx_dir    <= 1'b0;
      r_tx_baud   <= 3'd5;
      r_tx_par    <= 1'b0;
      r_busy      <= 1'b0;
      r_grant_id  <= 3'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_ptr       <= w_ptr_nxt;
      r_count     <= w_count_nxt;
      r_req_ready <= w_req_ready_nxt;
      r_tx_data   <= w_tx_data_nxt;
      r_tx_dir    <= w_tx_dir_nxt;
      r_tx_baud   <= w_tx_baud_nxt;
      r_tx_par    <= w_tx_par_nxt;
      r_busy      <= w_busy_nxt;
      r_grant_id  <= w_grant_id_nxt;
    end
  end

  assign bus.req_ready        = r_req_ready;
  assign bus.tx_data_in       = r_tx_data;
  assign bus.tx_data_in_ready = r_tx_dir;
  assign bus.tx_baud          = r_tx_baud;
  assign bus.tx_parity        = r_tx_par;
  assign bus.busy             = r_busy;
  assign bus.grant_id         = r_grant_id;

endmodule
